// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU/LSU producers, the register file port and decode forwarding.
interface regfile_write_arbiter_if #(
    parameter int unsigned LSU_DEPTH = 4
);
    localparam int unsigned CW = $clog2(LSU_DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_data;
    logic          wen;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [4:0]    fwd_raddr1;
    logic [4:0]    fwd_raddr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [31:0]   fwd_data1;
    logic [31:0]   fwd_data2;
    logic [CW-1:0] lsu_count;
    logic          busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_raddr1, fwd_raddr2,
        output alu_ready, lsu_ready, wen, waddr, wdata, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
               lsu_count, busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_raddr1, fwd_raddr2,
        input  alu_ready, lsu_ready, wen, waddr, wdata, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
               lsu_count, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and buffered LSU writeback onto one register-file write port,
// ALU-first with a starvation guard, and forwards the in-flight write to decode.
module regfile_write_arbiter #(
    parameter int unsigned LSU_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(LSU_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    wb_t           mem_q [LSU_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wen_q,    wen_d;
    logic [RW-1:0] waddr_q,  waddr_d;
    logic [DW-1:0] wdata_q,  wdata_d;

    logic fifo_nempty, fifo_full, force_lsu, push, grant_lsu, grant_alu;
    wb_t  head;

    assign fifo_nempty = (count_q != '0);
    assign fifo_full   = (count_q == CW'(LSU_DEPTH));
    assign force_lsu   = (starve_q >= SW'(STARVE_LIMIT));
    assign push        = bus.lsu_valid && !fifo_full;
    assign grant_lsu   = fifo_nempty && (force_lsu || !bus.alu_valid);
    assign grant_alu   = bus.alu_valid && !grant_lsu;
    assign head        = mem_q[rd_ptr_q];

    // Next-state: FIFO pointers/occupancy, starvation counter and the write-port register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (push)      wr_ptr_d = wr_ptr_q + PW'(1);
        if (grant_lsu) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, grant_lsu})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (grant_lsu || !fifo_nempty) begin
            starve_d = '0;
        end else if (grant_alu && !force_lsu) begin
            starve_d = starve_q + SW'(1);
        end

        if (grant_alu) begin
            wen_d   = (bus.alu_rd != '0);
            waddr_d = bus.alu_rd;
            wdata_d = bus.alu_data;
        end else if (grant_lsu) begin
            wen_d   = (head.rd != '0);
            waddr_d = head.rd;
            wdata_d = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
    end

    assign bus.alu_ready = !(force_lsu && fifo_nempty);
    assign bus.lsu_ready = !fifo_full;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.fwd_hit1  = wen_q && (waddr_q == bus.fwd_raddr1) && (bus.fwd_raddr1 != '0);
    assign bus.fwd_hit2  = wen_q && (waddr_q == bus.fwd_raddr2) && (bus.fwd_raddr2 != '0);
    assign bus.fwd_data1 = wdata_q;
    assign bus.fwd_data2 = wdata_q;
    assign bus.lsu_count = count_q;
    assign bus.busy      = fifo_nempty || wen_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    regfile_write_arbiter_if #(.LSU_DEPTH(4)) bus ();

    regfile_write_arbiter #(.LSU_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lsu_valid = v;
        bus.lsu_rd    = rd;
        bus.lsu_data  = d;
    endtask

    task automatic chk_w(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wen"}, 32'(bus.wen), 32'(wen));
        chk({tag, "_waddr"}, 32'(bus.waddr), 32'(a));
        chk({tag, "_wdata"}, bus.wdata, d);
    endtask

    initial begin
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        bus.fwd_raddr1 = 5'd0;
        bus.fwd_raddr2 = 5'd0;

        // Reset values
        #1 rst = 1'b0;
        #1;
        chk_w("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.lsu_count), 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_hit1", 32'(bus.fwd_hit1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Basic ALU write
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("alu_ready", 32'(bus.alu_ready), 32'd1);
        step();
        alu(1'b0, 5'd0, 32'h0);
        #1 chk_w("alu_wr", 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        chk_w("alu_idle", 1'b0, 5'd5, 32'hDEADBEEF);

        // LSU latency and forwarding
        lsu(1'b1, 5'd7, 32'h12345678);
        #1 chk("lsu_ready", 32'(bus.lsu_ready), 32'd1);
        step();
        lsu(1'b0, 5'd0, 32'h0);
        #1 chk("lsu_cnt1", 32'(bus.lsu_count), 32'd1);
        chk("lsu_wen_n1", 32'(bus.wen), 32'd0);
        step();
        bus.fwd_raddr1 = 5'd7;
        bus.fwd_raddr2 = 5'd0;
        #1 chk_w("lsu_wr", 1'b1, 5'd7, 32'h12345678);
        chk("fwd_hit1", 32'(bus.fwd_hit1), 32'd1);
        chk("fwd_data1", bus.fwd_data1, 32'h12345678);
        chk("fwd_hit2", 32'(bus.fwd_hit2), 32'd0);
        chk("lsu_busy", 32'(bus.busy), 32'd1);
        step();
        chk("lsu_done_wen", 32'(bus.wen), 32'd0);
        chk("lsu_done_hit1", 32'(bus.fwd_hit1), 32'd0);
        chk("lsu_done_busy", 32'(bus.busy), 32'd0);
        bus.fwd_raddr1 = 5'd0;

        // Starvation guard: LSU queued first, then continuous ALU
        lsu(1'b1, 5'd9, 32'h909);
        step();
        lsu(1'b0, 5'd0, 32'h0);
        alu(1'b1, 5'd1, 32'h11);
        #1 chk("stv_rdy0", 32'(bus.alu_ready), 32'd1);
        chk("stv_cnt0", 32'(bus.lsu_count), 32'd1);
        step();
        alu(1'b1, 5'd2, 32'h22);
        #1 chk_w("stv_w1", 1'b1, 5'd1, 32'h11);
        chk("stv_rdy1", 32'(bus.alu_ready), 32'd1);
        step();
        alu(1'b1, 5'd3, 32'h33);
        #1 chk_w("stv_w2", 1'b1, 5'd2, 32'h22);
        chk("stv_rdy2", 32'(bus.alu_ready), 32'd1);
        step();
        alu(1'b1, 5'd4, 32'h44);
        #1 chk_w("stv_w3", 1'b1, 5'd3, 32'h33);
        chk("stv_rdy_forced", 32'(bus.alu_ready), 32'd0);
        chk("stv_cnt_forced", 32'(bus.lsu_count), 32'd1);
        step();
        chk_w("stv_w9", 1'b1, 5'd9, 32'h909);
        chk("stv_rdy_after", 32'(bus.alu_ready), 32'd1);
        chk("stv_cnt_after", 32'(bus.lsu_count), 32'd0);
        step();
        alu(1'b0, 5'd0, 32'h0);
        #1 chk_w("stv_w4", 1'b1, 5'd4, 32'h44);
        step();
        chk("stv_idle", 32'(bus.wen), 32'd0);

        // FIFO full while ALU holds the port, then drain in order
        for (int i = 0; i < 4; i++) begin
            alu(1'b1, 5'(20 + i), 32'(32'hA0 + i));
            lsu(1'b1, 5'(24 + i), 32'(32'hB0 + i));
            #1 chk("full_fill_rdy", 32'(bus.lsu_ready), 32'd1);
            step();
            chk_w("full_fill_w", 1'b1, 5'(20 + i), 32'(32'hA0 + i));
        end
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b1, 5'd28, 32'hBAD);
        #1 chk("full_rdy", 32'(bus.lsu_ready), 32'd0);
        chk("full_cnt", 32'(bus.lsu_count), 32'd4);
        chk("full_alu_rdy", 32'(bus.alu_ready), 32'd0);
        step();
        lsu(1'b0, 5'd0, 32'h0);
        #1 chk("full_rdy_back", 32'(bus.lsu_ready), 32'd1);
        chk("full_cnt3", 32'(bus.lsu_count), 32'd3);
        chk_w("drain0", 1'b1, 5'd24, 32'hB0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_w("drain", 1'b1, 5'(24 + i), 32'(32'hB0 + i));
            chk("drain_cnt", 32'(bus.lsu_count), 32'(3 - i));
        end
        step();
        chk("drain_idle_wen", 32'(bus.wen), 32'd0);
        chk("drain_idle_busy", 32'(bus.busy), 32'd0);

        // Write to x0 is consumed but suppressed
        alu(1'b1, 5'd0, 32'hFFFFFFFF);
        #1 chk("x0_rdy", 32'(bus.alu_ready), 32'd1);
        step();
        alu(1'b0, 5'd0, 32'h0);
        bus.fwd_raddr1 = 5'd0;
        bus.fwd_raddr2 = 5'd0;
        #1 chk_w("x0", 1'b0, 5'd0, 32'hFFFFFFFF);
        chk("x0_hit1", 32'(bus.fwd_hit1), 32'd0);
        chk("x0_hit2", 32'(bus.fwd_hit2), 32'd0);
        chk("x0_busy", 32'(bus.busy), 32'd0);
        step();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            alu(1'b1, 5'(1 + i), 32'(32'hC0 + i));
            lsu(1'b1, 5'(10 + i), 32'(32'hD0 + i));
            step();
        end
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        #1 chk("mid_cnt", 32'(bus.lsu_count), 32'd3);
        chk_w("mid_w", 1'b1, 5'd3, 32'hC2);
        rst = 1'b0;
        #1 chk("mid_rst_wen", 32'(bus.wen), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_cnt", 32'(bus.lsu_count), 32'd0);
        chk("mid_rst_lsu_rdy", 32'(bus.lsu_ready), 32'd1);
        chk("mid_rst_alu_rdy", 32'(bus.alu_ready), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_wen", 32'(bus.wen), 32'd0);
            chk("post_rst_cnt", 32'(bus.lsu_count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Merges writeback results from the ALU (single-cycle, back-pressurable) and the load/store unit (buffered in a small FIFO) onto the single `regfile` write port (`wen`/`waddr`/`wdata`). It registers the winning result for one cycle and drives the port. While a write is in flight, it exposes that value on two bypass read ports so decode can forward it. Arbitration is fixed-priority ALU-first with a starvation guard for loads.

## Interface
- `LSU_DEPTH`, 4, LSU FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 3, consecutive ALU wins over a non-empty LSU FIFO before the LSU is forced; ≥1
- `clk` in 1: clock; all state updates on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `alu_valid` in 1: ALU result present
- `alu_ready` out 1: ALU result accepted this cycle when `alu_valid && alu_ready`
- `alu_rd` in 5: ALU destination register
- `alu_data` in 32: ALU result
- `lsu_valid` in 1: load result present
- `lsu_ready` out 1: FIFO not full; push when `lsu_valid && lsu_ready`
- `lsu_rd` in 5: load destination register
- `lsu_data` in 32: load data
- `wen` out 1: register file write enable
- `waddr` out 5: register file write address
- `wdata` out 32: register file write data
- `fwd_raddr1`, `fwd_raddr2` in 5: decode source registers
- `fwd_hit1`, `fwd_hit2` out 1: in-flight write matches source
- `fwd_data1`, `fwd_data2` out 32: forwarded value; equals `wdata`
- `lsu_count` out $clog2(LSU_DEPTH)+1: FIFO occupancy
- `busy` out 1: FIFO non-empty or `wen` high

## Operation
- **LSU FIFO.** Circular buffer with wrapping read and write pointers plus an occupancy counter.
  - `lsu_ready = (lsu_count != LSU_DEPTH)`. It is not pop-aware, so there is never a push while the FIFO is full.
  - Push and pop in the same cycle leaves the count unchanged.
  - There is no bypass: a push into an empty FIFO becomes poppable on the next cycle.
- **Grant each cycle (combinational).** The first matching rule wins:
  1. If `force_lsu` and the FIFO is non-empty, grant the LSU.
  2. Otherwise, if `alu_valid`, grant the ALU.
  3. Otherwise, if the FIFO is non-empty, grant the LSU.
  4. Otherwise, no grant.
- **ALU ready.** `force_lsu = (starve_cnt >= STARVE_LIMIT)`, and `alu_ready = !(force_lsu && lsu_count != 0)`.
- **Starvation counter** (`starve_cnt`, saturating at STARVE_LIMIT):
  - Increments when the ALU is granted while the FIFO is non-empty.
  - Clears to 0 when the LSU is granted or the FIFO is empty.
- **Output register.** On a grant, the winner's rd and data load into `waddr` and `wdata`, and `wen` is set to (rd != 0).
  - A granted write to x0 is consumed but produces `wen = 0`.
  - With no grant, `wen` goes to 0 and `waddr`/`wdata` hold their values.
- **Forwarding.** `fwd_hitN = wen && waddr == fwd_raddrN && fwd_raddrN != 0`, and `fwd_dataN = wdata`. Both are purely combinational.
- **Reset (`rst` low).** Takes effect immediately, regardless of clock.
  - Outputs: `wen = 0`, `waddr = 0`, `wdata = 0`, `fwd_hit* = 0`, `busy = 0`, `lsu_count = 0`, `lsu_ready = 1`, `alu_ready = 1`.
  - State: FIFO pointers and `starve_cnt` go to 0.
  - Reset asserted mid-operation discards all FIFO contents and any pending write. No write appears after deassertion unless a new result is accepted.

## Timing
- **ALU latency.** A result accepted at edge N drives `wen`/`waddr`/`wdata` during cycle N+1 (one cycle). The register file captures it at edge N+1.
- **LSU latency.** The minimum is 2 cycles: push at edge N, grant during cycle N+1, port driven in cycle N+2. Each preceding FIFO entry or ALU win adds one cycle.
- **Throughput.** At most one write per cycle. With continuous `alu_valid` and a non-empty FIFO, the pattern is STARVE_LIMIT ALU writes, then 1 LSU write, repeating.
- **Forwarding.** `fwd_*` are valid in the same cycle that `wen` is high. They cover exactly the cycle before the register file shows the new value.
- **FIFO full.** At `lsu_count == LSU_DEPTH`, `lsu_ready` is 0 in that cycle. It returns to 1 in the cycle after a pop.

## Test plan
- **Basic ALU write.** Reset, then `alu_valid` with rd=5, data=0xDEADBEEF for 1 cycle → next cycle `wen=1`, `waddr=5`, `wdata=0xDEADBEEF`; cycle after that `wen=0`.
- **LSU latency and forwarding.** Push LSU rd=7, data=0x12345678 with ALU idle → `wen`/`waddr=7` two cycles after the push. With `fwd_raddr1=7` in that cycle → `fwd_hit1=1`, `fwd_data1=0x12345678`; with `fwd_raddr2=0` → `fwd_hit2=0`.
- **Starvation guard.** Continuous ALU results rd=1..N plus one LSU push (rd=9) with STARVE_LIMIT=3 → 3 ALU writes, then rd=9, then ALU resumes. `alu_ready=0` during exactly the forced cycle, and the ALU data held across it is written next.
- **FIFO full.** Push 4 LSU entries while the ALU saturates the port → `lsu_ready=0`, `lsu_count=4`. Then release the ALU → entries drain in order, and `lsu_ready` returns to 1 after the first pop.
- **x0 write.** ALU rd=0, data=0xFFFFFFFF → consumed (`alu_ready=1`), `wen` stays 0, `fwd_hit*=0` for `fwd_raddr=0`.
- **Reset mid-operation.** With 3 LSU entries queued and `wen=1`, pulse `rst` low asynchronously between edges → `wen`, `busy`, and `lsu_count` drop to 0 immediately. After release with no new valids, no write occurs.
